// File: rtl/radix4_mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Optional early termination is selected with RADIX4_EARLY_TERM_EN.
package radix4_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  // Booth digit value, restricted to -2..+2
  typedef logic signed [2:0] booth_digit_t;

  // One digit per bit pair of the 2-bit-extended multiplier
  function automatic int n_dig(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window -> {neg, one, two} partial-product select.
module booth_digit_enc
  import radix4_mult_pkg::*;
(
  input  logic [2:0] win,
  output logic       neg,
  output logic       one,
  output logic       two
);

  // 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1
  always_comb begin
    one = win[1] ^ win[0];
    two = (win[2] ^ win[1]) & ~(win[1] ^ win[0]);
    neg = win[2] & ~(win[1] & win[0]);
  end

endmodule

// File: rtl/radix4_booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Define RADIX4_EARLY_TERM_EN to finish as soon as all remaining digits are zero.
module radix4_booth_mult_seq
  import radix4_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product
);

  localparam int N_DIG = n_dig(WIDTH);
  localparam int PW    = 2 * WIDTH;
  localparam int CW    = $clog2(N_DIG + 1);
  localparam int QW    = WIDTH + 3;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH+1:0]  m_ext;
  logic [QW-1:0]     q_win;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     cnt;

  logic              accept;
  logic [2:0]        win;
  logic              neg;
  logic              one;
  logic              two;
  logic [WIDTH+2:0]  mag;
  logic [WIDTH+2:0]  sel;
  logic [PW-1:0]     pp_ext;
  logic [PW-1:0]     pp_sh;
  logic              last_digit;
  logic              calc_finish;
  logic              add_en;

  assign accept     = in_valid && in_ready;
  assign win        = q_win[{cnt, 1'b0} +: 3];
  assign last_digit = (cnt == CW'(N_DIG - 1));

  booth_digit_enc u_enc (
    .win (win),
    .neg (neg),
    .one (one),
    .two (two)
  );

  // Partial product d*m_ext, sign-extended to the product width and placed at weight 4^i
  always_comb begin
    mag    = one ? {m_ext[WIDTH+1], m_ext} : (two ? {m_ext, 1'b0} : '0);
    sel    = neg ? (~mag + 1'b1) : mag;
    pp_ext = {{(PW - WIDTH - 3){sel[WIDTH+2]}}, sel};
    pp_sh  = pp_ext << {cnt, 1'b0};
  end

`ifdef RADIX4_EARLY_TERM_EN
  logic signed [QW-1:0] rem;
  logic                 rest_zero;

  // Remaining window bits all equal means every digit from here on is zero
  always_comb begin
    rem         = $signed(q_win) >>> {cnt, 1'b0};
    rest_zero   = (rem == '0) || (&rem);
    add_en      = !rest_zero;
    calc_finish = rest_zero || last_digit;
  end
`else
  always_comb begin
    add_en      = 1'b1;
    calc_finish = last_digit;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CALC;
      S_CALC:  if (calc_finish) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) && reset;
    out_valid = (state == S_DONE);
  end

  // Operands are extended once at accept; the accumulator is never shifted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ext <= '0;
      q_win <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      m_ext <= {{2{in_signed & in_m[WIDTH-1]}}, in_m};
      q_win <= {{2{in_signed & in_q[WIDTH-1]}}, in_q, 1'b0};
      acc   <= '0;
      cnt   <= '0;
    end else if ((state == S_CALC) && add_en) begin
      acc   <= acc + pp_sh;
      cnt   <= cnt + CW'(1);
    end
  end

  assign out_product = acc;

endmodule

// File: tb/tb_radix4_booth_mult_seq.sv
// Self-checking bench for radix4_booth_mult_seq (WIDTH=32), table-driven plus corner sequences.
module tb_radix4_booth_mult_seq;

  localparam int WIDTH = 32;
  localparam int N_DIG = WIDTH / 2 + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_signed = 1'b0;
  logic [WIDTH-1:0]  in_m = '0;
  logic [WIDTH-1:0]  in_q = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2*WIDTH-1:0] out_product;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  radix4_booth_mult_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .in_m        (in_m),
    .in_q        (in_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Edge count from the accepting edge (counted as 1) to the edge that raises out_valid
  function automatic int expected_edges(input logic sgn, input logic [31:0] q);
    logic [34:0] qx;
    logic [2:0]  w;
    int          last;
    int          d;
    int          cyc;
    qx   = {{2{sgn & q[31]}}, q, 1'b0};
    last = -1;
    for (int i = 0; i < N_DIG; i++) begin
      w = qx[2*i +: 3];
      d = (w[1] ? 1 : 0) + (w[0] ? 1 : 0) - (w[2] ? 2 : 0);
      if (d != 0) last = i;
    end
`ifdef RADIX4_EARLY_TERM_EN
    cyc = (last + 2 > N_DIG) ? N_DIG : last + 2;
`else
    cyc = N_DIG;
`endif
    return cyc + 1;
  endfunction

  task automatic apply_stimulus(input logic sgn, input logic [31:0] m, input logic [31:0] q,
                                input logic rdy, output logic [63:0] prod, output int edges);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_signed = sgn;
    in_m      = m;
    in_q      = q;
    out_ready = rdy;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_output("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    edges = 1;
    #1;
    in_valid  = 1'b0;
    in_m      = $urandom;
    in_q      = $urandom;
    in_signed = ~sgn;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
    end
    prod = out_product;
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [63:0] prod;
    logic [63:0] hold;
    logic [63:0] mx;
    logic [63:0] qx;
    logic [31:0] rm;
    logic [31:0] rq;
    logic        rs;
    int          edges;

    vecs[0]  = '{1'b1, 32'h00087234, 32'h00000348, 64'h000000001BB6BAA0};
    vecs[1]  = '{1'b1, 32'hFFFFFEFD, 32'hFFFFFEFD, 64'h0000000000010609};
    vecs[2]  = '{1'b1, 32'hB887CAAF, 32'h00000001, 64'hFFFFFFFFB887CAAF};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[4]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    vecs[5]  = '{1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000};
    vecs[6]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[7]  = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000};
    vecs[8]  = '{1'b0, 32'h00000000, 32'h12345678, 64'h0000000000000000};
    vecs[9]  = '{1'b1, 32'hFFFFFFFF, 32'h00000005, 64'hFFFFFFFFFFFFFFFB};
    vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'h00000005, 64'h00000004FFFFFFFB};
    vecs[11] = '{1'b1, 32'h12345678, 32'h00000000, 64'h0000000000000000};
    vecs[12] = '{1'b0, 32'h00000007, 32'h00000001, 64'h0000000000000007};

    // Reset state
    #1;
    check_output("reset_in_ready", 64'(in_ready), 64'd0);
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    check_output("reset_product", out_product, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("idle_in_ready", 64'(in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].sgn, vecs[i].m, vecs[i].q, 1'b1, prod, edges);
      check_output($sformatf("vec%0d_product", i), prod, vecs[i].exp);
      check_output($sformatf("vec%0d_latency", i), 64'(edges),
                   64'(expected_edges(vecs[i].sgn, vecs[i].q)));
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_valid_one_cycle", i), 64'(out_valid), 64'd0);
      check_output($sformatf("vec%0d_back_idle", i), 64'(in_ready), 64'd1);
    end

    // Backpressure in DONE with ignored in_valid pulses
    apply_stimulus(1'b0, 32'h0000FFFF, 32'h00010001, 1'b0, prod, edges);
    check_output("bp_product", prod, 64'h00000000FFFFFFFF);
    hold = prod;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k % 2 == 0);
      in_m     = $urandom;
      in_q     = $urandom;
      @(posedge clk);
      #1;
      check_output($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
      check_output($sformatf("bp%0d_product", k), out_product, hold);
      check_output($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp_release_valid", 64'(out_valid), 64'd0);
    check_output("bp_release_ready", 64'(in_ready), 64'd1);

    // Reset pulse mid-calculation discards the operation
    @(negedge clk);
    in_valid  = 1'b1;
    in_signed = 1'b0;
    in_m      = 32'h12345678;
    in_q      = 32'h76543210;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_output("midcalc_busy", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("midcalc_rst_in_ready", 64'(in_ready), 64'd0);
    check_output("midcalc_rst_out_valid", 64'(out_valid), 64'd0);
    check_output("midcalc_rst_product", out_product, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("midcalc_idle", 64'(in_ready), 64'd1);
    apply_stimulus(1'b1, 32'h00000001, 32'h50647236, 1'b1, prod, edges);
    check_output("after_rst_product", prod, 64'h0000000050647236);
    check_output("after_rst_latency", 64'(edges), 64'(expected_edges(1'b1, 32'h50647236)));

    // Random operands against a 64-bit reference product
    for (int r = 0; r < 20; r++) begin
      rm = $urandom;
      rq = $urandom;
      rs = 1'($urandom_range(0, 1));
      mx = rs ? {{32{rm[31]}}, rm} : {32'd0, rm};
      qx = rs ? {{32{rq[31]}}, rq} : {32'd0, rq};
      apply_stimulus(rs, rm, rq, 1'b1, prod, edges);
      check_output($sformatf("rand%0d_product", r), prod, mx * qx);
      check_output($sformatf("rand%0d_latency", r), 64'(edges), 64'(expected_edges(rs, rq)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
